// File: rtl/grs_rounder.sv
// -----------------------------------------------------------------------------
// grs_rounder
//
// Purpose:
//   Two-stage round-to-nearest-even unit. It sits directly after the sticky
//   right-shifter. The input fraction carries three trailing Guard/Round/Sticky
//   bits. The unit produces a DATA_WIDTH-bit rounded fraction. When rounding
//   carries out of the MSB, the fraction is renormalised and the exponent is
//   incremented. If that increment would reach the all-ones exponent, the
//   result saturates and m_overflow is raised. Both sides use a valid/ready
//   handshake, and the unit sustains full throughput.
//
// Optional feature:
//   `define ROUND_MODE_SELECT_EN adds the s_rnd_mode[1:0] input, which selects
//   the rounding mode: 00 RNE, 01 toward zero, 10 toward +inf, 11 toward -inf.
//   When the macro is undefined, the port is absent and the unit rounds RNE
//   only.
//
// Ports:
//   clk         clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   s_valid     upstream data valid
//   s_ready     unit can accept (combinationally depends on m_ready)
//   s_frac      {fraction, G, R, S}
//   s_exp       exponent of s_frac
//   s_sign      sign, passed through
//   s_rnd_mode  rounding mode (only with ROUND_MODE_SELECT_EN)
//   m_valid     result valid
//   m_ready     downstream accepts
//   m_frac      rounded fraction
//   m_exp       adjusted exponent
//   m_sign      sign
//   m_inexact   any of G/R/S was set
//   m_overflow  exponent saturated by rounding carry
// -----------------------------------------------------------------------------
module grs_rounder #(
    parameter int DATA_WIDTH = 16,
    parameter int EXP_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH+2:0]   s_frac,
    input  logic [EXP_WIDTH-1:0]    s_exp,
    input  logic                    s_sign,
`ifdef ROUND_MODE_SELECT_EN
    input  logic [1:0]              s_rnd_mode,
`endif
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH-1:0]   m_frac,
    output logic [EXP_WIDTH-1:0]    m_exp,
    output logic                    m_sign,
    output logic                    m_inexact,
    output logic                    m_overflow
);

    localparam logic [EXP_WIDTH-1:0] EXP_ONES = {EXP_WIDTH{1'b1}};
    // A carry from this exponent or above would land on the all-ones code.
    localparam logic [EXP_WIDTH-1:0] EXP_SAT  = {{(EXP_WIDTH-1){1'b1}}, 1'b0};

    // RNE: round up above the halfway point, and on an exact tie only when
    // the kept LSB is odd (ties to even).
    function automatic logic rne_round_up(input logic [2:0] grs, input logic lsb);
        return grs[2] & (grs[1] | grs[0] | lsb);
    endfunction

`ifdef ROUND_MODE_SELECT_EN
    function automatic logic mode_round_up(input logic [1:0] mode, input logic [2:0] grs,
                                           input logic lsb, input logic sign);
        logic inexact;
        inexact = |grs;
        case (mode)
            2'b00:   return rne_round_up(grs, lsb);
            2'b01:   return 1'b0;
            2'b10:   return inexact & ~sign;
            default: return inexact & sign;
        endcase
    endfunction
`endif

    logic                    vld_p1;
    logic [DATA_WIDTH-1:0]   trunc_p1;
    logic [EXP_WIDTH-1:0]    exp_p1;
    logic                    sign_p1;
    logic                    inexact_p1;
    logic                    round_up_p1;

    logic                    vld_p2;
    logic [DATA_WIDTH-1:0]   frac_p2;
    logic [EXP_WIDTH-1:0]    exp_p2;
    logic                    sign_p2;
    logic                    inexact_p2;
    logic                    overflow_p2;

    logic                    adv_p1;
    logic                    adv_p2;
    logic                    round_up_in;

    logic [DATA_WIDTH:0]     sum;
    logic [DATA_WIDTH-1:0]   frac_next;
    logic [EXP_WIDTH-1:0]    exp_next;
    logic                    overflow_next;

    // A stage may load when it is empty, or when its content moves on in the
    // same cycle.
    assign adv_p2  = ~vld_p2 | m_ready;
    assign adv_p1  = ~vld_p1 | adv_p2;
    assign s_ready = adv_p1;

`ifdef ROUND_MODE_SELECT_EN
    assign round_up_in = mode_round_up(s_rnd_mode, s_frac[2:0], s_frac[3], s_sign);
`else
    assign round_up_in = rne_round_up(s_frac[2:0], s_frac[3]);
`endif

    // ---- Stage 1: truncate, capture the round decision ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (adv_p1) begin
            vld_p1 <= s_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv_p1 && s_valid) begin
            trunc_p1    <= s_frac[DATA_WIDTH+2:3];
            exp_p1      <= s_exp;
            sign_p1     <= s_sign;
            inexact_p1  <= |s_frac[2:0];
            round_up_p1 <= round_up_in;
        end
    end

    // Increment, then renormalise or saturate on carry-out.
    always_comb begin
        sum           = {1'b0, trunc_p1} + (DATA_WIDTH+1)'(round_up_p1);
        frac_next     = sum[DATA_WIDTH-1:0];
        exp_next      = exp_p1;
        overflow_next = 1'b0;
        if (sum[DATA_WIDTH]) begin
            if (exp_p1 >= EXP_SAT) begin
                frac_next     = '0;
                exp_next      = EXP_ONES;
                overflow_next = 1'b1;
            end else begin
                frac_next = sum[DATA_WIDTH:1];
                exp_next  = exp_p1 + EXP_WIDTH'(1'b1);
            end
        end
    end

    // ---- Stage 2: output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2      <= 1'b0;
            frac_p2     <= '0;
            exp_p2      <= '0;
            sign_p2     <= 1'b0;
            inexact_p2  <= 1'b0;
            overflow_p2 <= 1'b0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                frac_p2     <= frac_next;
                exp_p2      <= exp_next;
                sign_p2     <= sign_p1;
                inexact_p2  <= inexact_p1;
                overflow_p2 <= overflow_next;
            end
        end
    end

    assign m_valid    = vld_p2;
    assign m_frac     = frac_p2;
    assign m_exp      = exp_p2;
    assign m_sign     = sign_p2;
    assign m_inexact  = inexact_p2;
    assign m_overflow = overflow_p2;

endmodule

// File: tb/tb_grs_rounder.sv
// -----------------------------------------------------------------------------
// tb_grs_rounder
//
// Purpose:
//   Testbench for grs_rounder at its default parameters (16-bit fraction,
//   8-bit exponent). It drives directed vectors, backpressure, reset and
//   random streaming. Results are compared against an arithmetic rounding
//   model. The ROUND_MODE_SELECT_EN macro enables the mode-select checks.
// -----------------------------------------------------------------------------
module tb_grs_rounder;

    localparam int DW = 16;
    localparam int EW = 8;

    logic            clk;
    logic            rst_n;
    logic            s_valid;
    logic            s_ready;
    logic [DW+2:0]   s_frac;
    logic [EW-1:0]   s_exp;
    logic            s_sign;
`ifdef ROUND_MODE_SELECT_EN
    logic [1:0]      s_rnd_mode;
`endif
    logic            m_valid;
    logic            m_ready;
    logic [DW-1:0]   m_frac;
    logic [EW-1:0]   m_exp;
    logic            m_sign;
    logic            m_inexact;
    logic            m_overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [DW-1:0] f;
        logic [EW-1:0] e;
        logic          o;
        logic          i;
        logic          s;
        int            c;
    } exp_t;

    exp_t sb[$];

    grs_rounder #(.DATA_WIDTH(DW), .EXP_WIDTH(EW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_frac     (s_frac),
        .s_exp      (s_exp),
        .s_sign     (s_sign),
`ifdef ROUND_MODE_SELECT_EN
        .s_rnd_mode (s_rnd_mode),
`endif
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_frac     (m_frac),
        .m_exp      (m_exp),
        .m_sign     (m_sign),
        .m_inexact  (m_inexact),
        .m_overflow (m_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round-to-nearest-even by integer arithmetic on the value scaled by 8.
    function automatic exp_t ref_model(input logic [DW+2:0] f, input logic [EW-1:0] e,
                                       input logic s);
        exp_t r;
        int unsigned q;
        int unsigned rem;
        q   = int'(f) / 8;
        rem = int'(f) % 8;
        r.i = (rem != 0);
        r.s = s;
        r.c = 0;
        if (rem > 4 || (rem == 4 && (q % 2) == 1)) q = q + 1;
        if (q == (1 << DW)) begin
            if (int'(e) >= (1 << EW) - 2) begin
                r.f = '0;
                r.e = '1;
                r.o = 1'b1;
            end else begin
                r.f = DW'(q / 2);
                r.e = EW'(int'(e) + 1);
                r.o = 1'b0;
            end
        end else begin
            r.f = DW'(q);
            r.e = e;
            r.o = 1'b0;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Sends one item into an empty pipeline with m_ready=1 and captures the
    // result. lat counts cycles from transfer to m_valid (-1 on timeout).
    task automatic send_one(input logic [DW+2:0] f, input logic [EW-1:0] e, input logic s,
                            output exp_t got, output int lat);
        int n;
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_frac  = f;
        s_exp   = e;
        s_sign  = s;
        #1;
        n = 0;
        while (!s_ready && n < 8) begin
            step();
            n++;
        end
        step();
        s_valid = 1'b0;
        lat = 1;
        while (!m_valid && lat < 8) begin
            step();
            lat++;
        end
        got.f = m_frac;
        got.e = m_exp;
        got.o = m_overflow;
        got.i = m_inexact;
        got.s = m_sign;
        got.c = 0;
        if (!m_valid) lat = -1;
        step();
    endtask

    task automatic test_reset();
        n_tests++;
        if ({m_valid, m_frac, m_exp, m_sign, m_inexact, m_overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b f=%h e=%h s=%b i=%b o=%b want all 0",
                     m_valid, m_frac, m_exp, m_sign, m_inexact, m_overflow);
        end
    endtask

    task automatic test_rne_ties();
        exp_t g;
        int   lat;
        send_one({16'h00A5, 3'b100}, 8'h10, 1'b0, g, lat);
        n_tests++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL tie_odd_latency got %0d want 2", lat);
        end
        n_tests++;
        if ({g.f, g.e, g.i, g.o} !== {16'h00A6, 8'h10, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL tie_odd got f=%h e=%h i=%b o=%b want f=00a6 e=10 i=1 o=0",
                     g.f, g.e, g.i, g.o);
        end
        send_one({16'h00A4, 3'b100}, 8'h10, 1'b0, g, lat);
        n_tests++;
        if ({g.f, g.i} !== {16'h00A4, 1'b1}) begin
            n_fail++;
            $display("FAIL tie_even got f=%h i=%b want f=00a4 i=1", g.f, g.i);
        end
        send_one({16'h00A4, 3'b011}, 8'h10, 1'b0, g, lat);
        n_tests++;
        if ({g.f, g.i} !== {16'h00A4, 1'b1}) begin
            n_fail++;
            $display("FAIL below_half got f=%h i=%b want f=00a4 i=1", g.f, g.i);
        end
        send_one({16'h1234, 3'b000}, 8'h33, 1'b1, g, lat);
        n_tests++;
        if ({g.f, g.e, g.i, g.s} !== {16'h1234, 8'h33, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL exact got f=%h e=%h i=%b s=%b want f=1234 e=33 i=0 s=1",
                     g.f, g.e, g.i, g.s);
        end
    endtask

    task automatic test_carry();
        exp_t g;
        int   lat;
        send_one({16'hFFFF, 3'b110}, 8'h05, 1'b0, g, lat);
        n_tests++;
        if ({g.f, g.e, g.o} !== {16'h8000, 8'h06, 1'b0}) begin
            n_fail++;
            $display("FAIL carry_renorm got f=%h e=%h o=%b want f=8000 e=06 o=0", g.f, g.e, g.o);
        end
        send_one({16'hFFFF, 3'b110}, 8'hFD, 1'b0, g, lat);
        n_tests++;
        if ({g.f, g.e, g.o} !== {16'h8000, 8'hFE, 1'b0}) begin
            n_fail++;
            $display("FAIL carry_fd got f=%h e=%h o=%b want f=8000 e=fe o=0", g.f, g.e, g.o);
        end
        send_one({16'hFFFF, 3'b110}, 8'hFE, 1'b1, g, lat);
        n_tests++;
        if ({g.f, g.e, g.o, g.s} !== {16'h0000, 8'hFF, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL carry_overflow got f=%h e=%h o=%b s=%b want f=0000 e=ff o=1 s=1",
                     g.f, g.e, g.o, g.s);
        end
        send_one({16'hFFFF, 3'b011}, 8'hFE, 1'b0, g, lat);
        n_tests++;
        if ({g.f, g.e, g.o} !== {16'hFFFF, 8'hFE, 1'b0}) begin
            n_fail++;
            $display("FAIL no_carry_fe got f=%h e=%h o=%b want f=ffff e=fe o=0", g.f, g.e, g.o);
        end
    endtask

    task automatic test_backpressure();
        exp_t a, b, c;
        a = ref_model({16'h0101, 3'b101}, 8'h11, 1'b0);
        b = ref_model({16'h0202, 3'b100}, 8'h22, 1'b1);
        c = ref_model({16'h0303, 3'b111}, 8'h33, 1'b0);
        m_ready = 1'b0;
        s_valid = 1'b1; s_frac = {16'h0101, 3'b101}; s_exp = 8'h11; s_sign = 1'b0;
        #1;
        n_tests++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept_a got s_ready=%b want 1", s_ready);
        end
        step();
        s_frac = {16'h0202, 3'b100}; s_exp = 8'h22; s_sign = 1'b1;
        #1;
        n_tests++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept_b got s_ready=%b want 1", s_ready);
        end
        step();
        s_frac = {16'h0303, 3'b111}; s_exp = 8'h33; s_sign = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if ({s_ready, m_valid, m_frac, m_exp} !== {1'b0, 1'b1, a.f, a.e}) begin
                n_fail++;
                $display("FAIL bp_hold_%0d got s_ready=%b v=%b f=%h e=%h want 0 1 %h %h",
                         k, s_ready, m_valid, m_frac, m_exp, a.f, a.e);
            end
            step();
        end
        m_ready = 1'b1;
        #1;
        n_tests++;
        if ({s_ready, m_valid, m_frac} !== {1'b1, 1'b1, a.f}) begin
            n_fail++;
            $display("FAIL bp_out_a got s_ready=%b v=%b f=%h want 1 1 %h",
                     s_ready, m_valid, m_frac, a.f);
        end
        step();
        s_valid = 1'b0;
        n_tests++;
        if ({m_valid, m_frac, m_exp, m_sign} !== {1'b1, b.f, b.e, b.s}) begin
            n_fail++;
            $display("FAIL bp_out_b got v=%b f=%h e=%h s=%b want 1 %h %h %b",
                     m_valid, m_frac, m_exp, m_sign, b.f, b.e, b.s);
        end
        step();
        n_tests++;
        if ({m_valid, m_frac, m_exp} !== {1'b1, c.f, c.e}) begin
            n_fail++;
            $display("FAIL bp_out_c got v=%b f=%h e=%h want 1 %h %h",
                     m_valid, m_frac, m_exp, c.f, c.e);
        end
        step();
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drained got v=%b want 0", m_valid);
        end
    endtask

    task automatic test_streaming();
        int   sent, recv, guard;
        exp_t e;
        logic [DW+2:0] f;
        sent = 0; recv = 0; guard = 0;
        sb.delete();
        m_ready = 1'b1;
        while ((sent < 100 || sb.size() > 0) && guard < 300) begin
            if (sent < 100) begin
                f = (DW+3)'($urandom);
                if ($urandom_range(0, 3) == 0) f[DW+2:3] = '1;
                s_valid = 1'b1;
                s_frac  = f;
                s_exp   = ($urandom_range(0, 3) == 0) ? EW'($urandom_range(252, 255))
                                                      : EW'($urandom);
                s_sign  = 1'($urandom);
            end else begin
                s_valid = 1'b0;
            end
            #1;
            if (s_valid) begin
                n_tests++;
                if (s_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_ready cycle %0d got s_ready=%b want 1", cyc, s_ready);
                end
            end
            if (m_valid && m_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra got unexpected output f=%h want none", m_frac);
                end else begin
                    e = sb.pop_front();
                    recv++;
                    if ({m_frac, m_exp, m_overflow, m_inexact, m_sign} !== {e.f, e.e, e.o, e.i, e.s}
                        || cyc != e.c + 2) begin
                        n_fail++;
                        $display("FAIL stream_item %0d got f=%h e=%h o=%b i=%b s=%b cyc=%0d want f=%h e=%h o=%b i=%b s=%b cyc=%0d",
                                 recv, m_frac, m_exp, m_overflow, m_inexact, m_sign, cyc,
                                 e.f, e.e, e.o, e.i, e.s, e.c + 2);
                    end
                end
            end
            if (s_valid && s_ready) begin
                e   = ref_model(s_frac, s_exp, s_sign);
                e.c = cyc;
                sb.push_back(e);
                sent++;
            end
            step();
            guard++;
        end
        s_valid = 1'b0;
        n_tests++;
        if (recv != 100) begin
            n_fail++;
            $display("FAIL stream_count got %0d want 100", recv);
        end
    endtask

    task automatic test_reset_midflight();
        exp_t g;
        int   lat;
        m_ready = 1'b0;
        s_valid = 1'b1; s_frac = {16'h0F0F, 3'b001}; s_exp = 8'h44; s_sign = 1'b1;
        step();
        s_frac = {16'h7777, 3'b111};
        step();
        s_valid = 1'b0;
        n_tests++;
        if ({m_valid, s_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_mid_full got v=%b s_ready=%b want 1 0", m_valid, s_ready);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({m_valid, m_frac, m_exp, m_sign, m_inexact} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_async got v=%b f=%h e=%h s=%b i=%b want all 0",
                     m_valid, m_frac, m_exp, m_sign, m_inexact);
        end
        step();
        step();
        rst_n   = 1'b1;
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            if (m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_stale_%0d got v=%b want 0", k, m_valid);
            end
        end
        send_one({16'h0100, 3'b111}, 8'h01, 1'b0, g, lat);
        n_tests++;
        if ({g.f, lat} !== {16'h0101, 32'sd2}) begin
            n_fail++;
            $display("FAIL rst_mid_resume got f=%h lat=%0d want f=0101 lat=2", g.f, lat);
        end
    endtask

`ifdef ROUND_MODE_SELECT_EN
    task automatic test_round_modes();
        exp_t g;
        int   lat;
        logic [1:0]    modes [3] = '{2'b10, 2'b01, 2'b11};
        logic [DW-1:0] want  [3] = '{16'h00A5, 16'h00A4, 16'h00A4};
        for (int k = 0; k < 3; k++) begin
            s_rnd_mode = modes[k];
            send_one({16'h00A4, 3'b001}, 8'h10, 1'b0, g, lat);
            n_tests++;
            if (g.f !== want[k]) begin
                n_fail++;
                $display("FAIL mode_%b got f=%h want %h", modes[k], g.f, want[k]);
            end
        end
        s_rnd_mode = 2'b11;
        send_one({16'h00A4, 3'b001}, 8'h10, 1'b1, g, lat);
        n_tests++;
        if (g.f !== 16'h00A5) begin
            n_fail++;
            $display("FAIL mode_11_neg got f=%h want 00a5", g.f);
        end
        s_rnd_mode = 2'b00;
    endtask
`endif

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_frac  = '0;
        s_exp   = '0;
        s_sign  = 1'b0;
        m_ready = 1'b0;
`ifdef ROUND_MODE_SELECT_EN
        s_rnd_mode = 2'b00;
`endif
        step();
        step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_rne_ties();
        test_carry();
        test_backpressure();
        test_streaming();
        test_reset_midflight();
`ifdef ROUND_MODE_SELECT_EN
        test_round_modes();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/grs_rounder.md
Name: grs_rounder

Overview:
Pipelined round-to-nearest-even stage placed directly downstream of the sticky right-shifter. It consumes a fraction that carries 3 trailing Guard/Round/Sticky bits (width DATA_WIDTH+3) plus its exponent and sign. It produces a DATA_WIDTH-bit rounded fraction with renormalisation on carry-out, an exponent increment, and overflow/inexact flags. Valid/ready handshake on both sides, two register stages, full throughput.

Parameters:
DATA_WIDTH, 16, fraction width excluding GRS bits; the MSB is the explicit leading bit.
EXP_WIDTH, 8, unsigned biased exponent width.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
s_valid  in  1  upstream data valid
s_ready  out  1  block can accept
s_frac  in  DATA_WIDTH+3  {fraction, G, R, S}; bit 2=G, bit 1=R, bit 0=S
s_exp  in  EXP_WIDTH  exponent of s_frac
s_sign  in  1  sign, passed through
m_valid  out  1  result valid
m_ready  in  1  downstream accepts
m_frac  out  DATA_WIDTH  rounded fraction
m_exp  out  EXP_WIDTH  adjusted exponent
m_sign  out  1  sign
m_inexact  out  1  any of G/R/S was set
m_overflow  out  1  exponent saturated by rounding carry

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous, active-low. All valid bits and all outputs reset to 0.
- Stage 1 (S1):
  - Registers trunc = s_frac[DATA_WIDTH+2:3], s_exp, s_sign.
  - Registers inexact = |s_frac[2:0].
  - Registers round_up = G & (R | S | lsb), where lsb = s_frac[3] (RNE; ties to even).
- Stage 2 (S2) computes sum = {1'b0,trunc} + round_up, which is DATA_WIDTH+1 bits.
  - No carry (sum[DATA_WIDTH]=0): m_frac = sum[DATA_WIDTH-1:0], m_exp = exp.
  - Carry: m_frac = sum[DATA_WIDTH:1] (= 1000...0), m_exp = exp+1.
  - Carry and exp >= 2^EXP_WIDTH-2: m_exp = all ones, m_frac = 0, m_overflow = 1.
  - m_overflow is 0 in every other case.
  - m_inexact and m_sign are forwarded from S1.
- Latency: 2 cycles from s_valid&s_ready to m_valid, when not stalled. Throughput is 1 per cycle.
- Handshake (per stage):
  - S2 advance = !v2 | m_ready. S1 advance = !v1 | S2 advance. s_ready = S1 advance.
  - A transfer occurs only on valid&ready.
  - m_* outputs are held stable while m_valid & !m_ready.
  - No combinational path from s_valid to m_valid.
  - s_ready depends combinationally on m_ready; this path is accepted.
- Bubbles: an empty stage always accepts. Data registers update only on accept; valid bits clear when a stage empties.
- Simultaneous accept upstream and drain downstream in the same cycle: both occur, no loss, no duplication.
- Full pipeline with m_ready=0: s_ready=0, both stages hold.
- Ordering is strictly FIFO; the block holds at most 2 results.
- Reset mid-operation: in-flight data is discarded. m_valid=0 on the first cycle after rst_n deasserts.
- s_frac[2:0] = 0: exact; m_frac = trunc, m_inexact = 0.

Optional Feature:
Macro ROUND_MODE_SELECT_EN.
- Defined:
  - Adds input s_rnd_mode [1:0], captured with s_frac in S1.
  - Modes: 00 RNE, 01 toward zero (round_up=0), 10 toward +inf (round_up = inexact & !sign), 11 toward -inf (round_up = inexact & sign).
  - Overflow/renormalisation rules are unchanged.
- Undefined: the port is absent and the behaviour is RNE only.
- Default build is undefined.

Test Plan:
- Tie, odd: s_frac={16'h00A5,3'b100}, s_exp=8'h10 -> 2 cycles later m_frac=16'h00A6, m_exp=8'h10, m_inexact=1, m_overflow=0.
- Tie, even: {16'h00A4,3'b100} -> m_frac=16'h00A4, m_inexact=1. Also {16'h00A4,3'b011} -> m_frac=16'h00A4. Exact {16'h1234,3'b000} -> m_frac=16'h1234, m_inexact=0.
- Carry renormalise: {16'hFFFF,3'b110}, s_exp=8'h05 -> m_frac=16'h8000, m_exp=8'h06. With s_exp=8'hFE -> m_exp=8'hFF, m_frac=0, m_overflow=1.
- Backpressure:
  - Stimulus: m_ready=0, three back-to-back inputs A,B,C.
  - Required: s_ready=0 after A and B are held and C stalls; m_frac shows A stable.
  - Then raise m_ready: A,B,C emerge on consecutive cycles in order, none dropped or duplicated.
- Streaming: 100 random inputs with m_ready=1 -> one output per cycle, 2-cycle latency, results match the reference model.
- Reset: assert rst_n low while both stages are valid -> m_valid=0 immediately (asynchronous), no stale output after release.
- (ROUND_MODE_SELECT_EN) {16'h00A4,3'b001}, sign=0: mode 10 -> 16'h00A5; mode 01 -> 16'h00A4; mode 11 -> 16'h00A4.
